// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: 16-way round-robin arbiter with registered one-hot grant and ready handshake; define RR_ARB_LOCK_EN to add the lock input
module rr_arbiter_16 #(
  parameter logic [3:0] PTR_INIT = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  output logic [15:0] gnt,
  output logic        gnt_valid,
  input  logic        gnt_ready
`ifdef RR_ARB_LOCK_EN
  ,
  input  logic        lock
`endif
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t      state;
  logic [3:0]  ptr, widx, base, win;
  logic [15:0] win_oh;
  logic        any, hold;
  // Binary index of the currently held grant
  always_comb begin
    widx = '0;
    for (int i = 0; i < 16; i++) widx = gnt[i] ? (widx | 4'(i)) : widx;
  end
  // Scan starts at the pointer the transfer would produce, so back-to-back grants need no extra cycle
  always_comb begin
    base = (state == GRANT) ? widx + 4'd1 : ptr;
    win  = '0;
    for (int i = 15; i >= 0; i--) win = req[base + 4'(i)] ? base + 4'(i) : win;
    win_oh = 16'd1 << win;
    any    = |req;
  end
  // A locked transfer keeps the current winner and pointer as long as it still requests
`ifdef RR_ARB_LOCK_EN
  always_comb hold = lock & req[widx];
`else
  always_comb hold = 1'b0;
`endif
  // Grant state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      ptr       <= PTR_INIT;
    end else begin
      case (state)
        IDLE: if (any) begin
          state     <= GRANT;
          gnt       <= win_oh;
          gnt_valid <= 1'b1;
        end
        GRANT: if (gnt_ready && !hold) begin
          ptr       <= widx + 4'd1;
          state     <= any ? GRANT : IDLE;
          gnt       <= any ? win_oh : '0;
          gnt_valid <= any;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb_rr_arbiter_16: table-driven scoreboard bench for the 16-way round-robin arbiter
module tb_rr_arbiter_16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] gnt;
  logic        gnt_valid;
  logic        gnt_ready = 1'b0;
`ifdef RR_ARB_LOCK_EN
  logic        lock = 1'b0;
`endif

  typedef struct {
    logic [15:0] req;
    logic        rdy;
    logic [15:0] eg;
    logic        ev;
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] sb[$];
  int          n_chk = 0;
  int          n_fail = 0;

  rr_arbiter_16 dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .gnt_valid(gnt_valid), .gnt_ready(gnt_ready)
`ifdef RR_ARB_LOCK_EN
    , .lock(lock)
`endif
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int idx, input logic [16:0] act, input logic [16:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got valid=%b gnt=%h, expected valid=%b gnt=%h", name, idx, act[16], act[15:0], exp[16], exp[15:0]);
    end
  endtask

  task automatic step(input string name, input int idx, input logic [15:0] r, input logic rd, input logic [15:0] eg, input logic ev);
    logic [16:0] e;
    @(negedge clk);
    req = r;
    gnt_ready = rd;
    sb.push_back({ev, eg});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s[%0d]: scoreboard empty", name, idx);
    end else begin
      e = sb.pop_front();
      cmp(name, idx, {gnt_valid, gnt}, e);
    end
  endtask

  function automatic void add(input logic [15:0] r, input logic rd, input logic [15:0] eg, input logic ev);
    vec_t v;
    v.req = r; v.rdy = rd; v.eg = eg; v.ev = ev;
    vecs.push_back(v);
  endfunction

  task automatic pulse_reset(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    cmp(name, 0, {gnt_valid, gnt}, 17'h0);
    @(posedge clk);
    #1;
    cmp(name, 1, {gnt_valid, gnt}, 17'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 10; i++) add(16'h0000, 1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 6; i++) add(16'h0021, 1'b1, (i % 2 == 0) ? 16'h0001 : 16'h0020, 1'b1);
    add(16'h0000, 1'b1, 16'h0000, 1'b0);
    add(16'h0000, 1'b1, 16'h0000, 1'b0);
    add(16'h4000, 1'b1, 16'h4000, 1'b1);
    add(16'h8001, 1'b1, 16'h8000, 1'b1);
    add(16'h8001, 1'b1, 16'h0001, 1'b1);
    add(16'h0000, 1'b1, 16'h0000, 1'b0);
    add(16'h0004, 1'b0, 16'h0004, 1'b1);
    for (int i = 0; i < 5; i++) add(16'h0100, 1'b0, 16'h0004, 1'b1);
    add(16'h0100, 1'b1, 16'h0100, 1'b1);
    add(16'h0000, 1'b1, 16'h0000, 1'b0);
    add(16'h0202, 1'b0, 16'h0200, 1'b1);
    add(16'h0202, 1'b0, 16'h0200, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    cmp("reset", 0, {gnt_valid, gnt}, 17'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) step("vec", i, vecs[i].req, vecs[i].rdy, vecs[i].eg, vecs[i].ev);

    pulse_reset("mid_grant_reset");
    step("after_reset", 0, 16'h0202, 1'b0, 16'h0002, 1'b1);
    for (int k = 0; k < 17; k++)
      step("rotate", k, 16'hFFFF, 1'b1, 16'h0001 << ((2 + k) % 16), 1'b1);
    step("drain", 0, 16'h0000, 1'b1, 16'h0000, 1'b0);

`ifdef RR_ARB_LOCK_EN
    pulse_reset("lock_reset");
    lock = 1'b1;
    step("lock", 0, 16'h0003, 1'b1, 16'h0001, 1'b1);
    for (int k = 1; k <= 3; k++) step("lock", k, 16'h0003, 1'b1, 16'h0001, 1'b1);
    lock = 1'b0;
    step("unlock", 0, 16'h0003, 1'b1, 16'h0002, 1'b1);
    lock = 1'b1;
    step("lock_drop", 0, 16'h0001, 1'b1, 16'h0001, 1'b1);
    lock = 1'b0;
`endif

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_16.md
RR_ARBITER_16 -- requirements
Module: rr_arbiter_16

Interface
REQ-001 SHALL have parameter PTR_INIT, default 4'd0: index given top priority after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  16  request lines; bit i = requester i.
REQ-005 SHALL have port gnt  output  16  registered grant, one-hot or zero; feeds the one-hot-to-binary encoder stage.
REQ-006 SHALL have port gnt_valid  output  1  gnt holds a valid one-hot grant.
REQ-007 SHALL have port gnt_ready  input  1  downstream accepts grant; transfer = gnt_valid & gnt_ready.
REQ-008 SHALL have port lock  input  1  present only under RR_ARB_LOCK_EN (see Configuration).

Function
REQ-009 SHALL implement two states: IDLE (gnt_valid=0, gnt=0) and GRANT (gnt_valid=1, gnt one-hot).
REQ-010 SHALL hold a 4-bit priority pointer ptr; arbitration picks the first set req bit scanning ptr, ptr+1, ... 15, 0, ... ptr-1 (mod 16).
REQ-011 SHALL move IDLE->GRANT on the rising edge at which req != 0, loading gnt with the winner; latency req-to-gnt_valid = 1 cycle.
REQ-012 SHALL remain in IDLE with gnt=0 while req == 0.
REQ-013 SHALL hold gnt and gnt_valid constant in GRANT while gnt_ready=0, regardless of req changes, including the granted bit dropping.
REQ-014 SHALL, on transfer, set ptr to (winner index + 1) mod 16; winner 15 wraps ptr to 0.
REQ-015 SHALL, on transfer with req != 0 at that edge, load the next winner (scanned from the updated ptr) and stay in GRANT: back-to-back grants, no bubble.
REQ-016 SHALL, on transfer with req == 0 at that edge, return to IDLE with gnt=0.
REQ-017 SHALL guarantee no requester holding req continuously waits more than 15 transfers.
REQ-018 SHALL never assert more than one gnt bit; gnt=0 whenever gnt_valid=0.

Reset
REQ-019 SHALL, while rst_n=0, force state=IDLE, gnt=16'h0000, gnt_valid=0, ptr=PTR_INIT, asynchronously.
REQ-020 SHALL drop a pending, unaccepted grant on reset mid-GRANT; the first arbitration after reset release uses ptr=PTR_INIT.
REQ-021 SHALL evaluate its first arbitration on the first rising edge with rst_n=1.

Configuration
REQ-022 SHALL compile the lock feature in only when macro RR_ARB_LOCK_EN is defined.
REQ-023 SHALL, with RR_ARB_LOCK_EN defined: at a transfer with lock=1 and req[winner]=1, re-grant the same winner next cycle and leave ptr unchanged; with lock=1 and req[winner]=0, behave as lock=0.
REQ-024 SHALL, without RR_ARB_LOCK_EN, omit the lock port entirely and behave per REQ-009..REQ-018.

Verification
REQ-025 SHALL cover reset then req=16'h0000 for 10 cycles -> gnt_valid=0, gnt=16'h0000 throughout.
REQ-026 SHALL cover req=16'h0021, gnt_ready=1 constantly -> grants 16'h0001, 16'h0020, 16'h0001, ... on consecutive cycles, no bubble.
REQ-027 SHALL cover req=16'h8001 with ptr at 15 -> gnt=16'h8000, then ptr wraps to 0 -> gnt=16'h0001.
REQ-028 SHALL cover gnt=16'h0004 held, gnt_ready=0 for 5 cycles while req changes to 16'h0100 -> gnt stays 16'h0004 until ready, then 16'h0100.
REQ-029 SHALL cover rst_n pulsed low mid-GRANT -> gnt=0, gnt_valid=0 immediately, next grant scanned from PTR_INIT.
REQ-030 SHALL cover, with RR_ARB_LOCK_EN, req=16'h0003 and lock=1 -> 16'h0001 re-granted on 3 transfers; lock=0 -> next grant 16'h0002.
